// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the 4-phase REQ/ACK source-side transfer controller:
// FSM state encoding and default parameter values.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ_HI = 2'b01,
    REQ_LO = 2'b10
  } hs_state_e;

  localparam int unsigned DEF_BUS_WIDTH      = 8;
  localparam int unsigned DEF_NUM_STAGES     = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/sync_ff_chain.sv
// 1-bit flop chain used to bring an asynchronous level into the CLK domain.
// Only the last stage is safe to use; earlier stages may be metastable.
module sync_ff_chain #(
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d_in,
  output logic q_out
);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("sync_ff_chain: NUM_STAGES must be at least 2");
  end

  logic [NUM_STAGES-1:0] chain_q;
  logic [NUM_STAGES-1:0] chain_d;

  // Shift the input one stage deeper every cycle.
  always_comb begin
    chain_d = {chain_q[NUM_STAGES-2:0], d_in};
  end

  // Chain flops, cleared by the synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_out = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx_ctrl.sv
// Source-side 4-phase REQ/ACK controller for moving a multi-bit word across a
// clock-domain boundary. The word is captured on acceptance and held on
// DATA_OUT while REQ/ACK complete a full 4-phase cycle.
//
// Optional build macro CDC_HS_TIMEOUT_EN: when defined, a handshake that sits
// in REQ_HI or REQ_LO for TIMEOUT_CYCLES cycles is aborted with an ERR pulse.
// When undefined, ERR is tied low and the FSM waits for ACK forever.
//
// state  | meaning
// IDLE   | ready for a new word, REQ low
// REQ_HI | REQ high, waiting for synchronized ACK to rise
// REQ_LO | REQ low, waiting for synchronized ACK to fall
module cdc_hs_tx_ctrl
  import cdc_hs_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  input  logic                 ACK_ASYNC,
  output logic                 REQ,
  output logic [BUS_WIDTH-1:0] DATA_OUT,
  output logic                 DONE,
  output logic                 ERR
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cdc_hs_tx_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  hs_state_e            state_q, state_d;
  logic                 req_q, req_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ack_s;
  logic                 timeout_hit;

  sync_ff_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .CLK  (CLK),
    .RST  (RST),
    .d_in (ACK_ASYNC),
    .q_out(ack_s)
  );

`ifdef CDC_HS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The count is the number of edges already spent in the current wait state,
  // so hitting TIMEOUT_CYCLES-1 here means this edge is the TIMEOUT_CYCLES-th.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles in a wait state; restart on any state change and in IDLE.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_d != state_q) || (state_q == IDLE)) begin
      cnt_d = '0;
    end
  end

  // Error pulse fires on the edge that aborts a stalled handshake.
  always_comb begin
    err_d = 1'b0;
    if (((state_q == REQ_HI) && !ack_s) || ((state_q == REQ_LO) && ack_s)) begin
      err_d = timeout_hit;
    end
  end

  // Timeout counter and error pulse flops.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign timeout_hit = 1'b0;
  assign ERR         = 1'b0;
`endif

  // Next-state and registered-output logic for the 4-phase sequence.
  // ACK progress wins over a timeout that lands on the same edge.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TX_VALID) begin
          data_d  = TX_DATA;
          req_d   = 1'b1;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset mid-transfer drops REQ immediately.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign TX_READY = (state_q == IDLE);
  assign REQ      = req_q;
  assign DATA_OUT = data_q;
  assign DONE     = done_q;

endmodule
